// File: rtl/conv_pkg.sv
// Shared constants and state type for the convolution scan sequencer.
package conv_pkg;

  localparam int KW = 3;             // kernel width/height
  localparam int OW = 19;            // output positions per axis
  localparam int AW = 4;             // weight-bank address width
  localparam int XW = $clog2(KW);    // inner counter width
  localparam int PW = $clog2(OW);    // outer counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/conv_scan_ctrl_count.sv
// Mod-N counter with synchronous clear; terminal-count flag is combinational.
module count_mod #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         max
);

  assign max = (q == W'(N - 1));

  // Count 0..N-1 while enabled, wrapping at N-1; clear takes priority.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= max ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/conv_scan_ctrl.sv
// Kernel-weight load and scan sequencer for the convolution datapath.
module conv_scan_ctrl #(
  parameter int KW = conv_pkg::KW,
  parameter int OW = conv_pkg::OW,
  parameter int AW = conv_pkg::AW,
  parameter int XW = conv_pkg::XW,
  parameter int PW = conv_pkg::PW
) (
  input  logic          clk,
  input  logic          xrst,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic [AW-1:0] w_raddr,
  output logic          ld_we,
  output logic [AW-1:0] ld_idx,
  output logic [XW-1:0] x,
  output logic [XW-1:0] y,
  output logic [PW-1:0] X,
  output logic [PW-1:0] Y,
  output logic          mac_en,
  output logic          acc_clr,
  output logic          acc_valid,
  output logic          shift_x,
  output logic          shift_row,
  output logic          finish
);

  import conv_pkg::*;

  localparam logic [AW-1:0] LAST_ADDR = AW'(KW * KW - 1);

  state_t state, state_nxt;
  logic   addr_vld;   // address phase of LOAD still issuing reads
  logic   step_q;     // this cycle is an unstalled SCAN step
  logic   cnt_clr;
  logic   en_y, en_X, en_Y;
  logic   x_max, y_max, X_max, Y_max;
  logic   last_step;

  // Counters clear on reset and in DONE; each stage carries into the next.
  assign cnt_clr   = !xrst || (state == DONE);
  assign en_y      = step_q && x_max;
  assign en_X      = en_y && y_max;
  assign en_Y      = en_X && X_max;
  assign last_step = en_Y && Y_max;

  count_mod #(.N(KW), .W(XW)) u_cnt_x (
    .clk(clk), .clr(cnt_clr), .en(step_q), .q(x), .max(x_max)
  );
  count_mod #(.N(KW), .W(XW)) u_cnt_y (
    .clk(clk), .clr(cnt_clr), .en(en_y), .q(y), .max(y_max)
  );
  count_mod #(.N(OW), .W(PW)) u_cnt_xo (
    .clk(clk), .clr(cnt_clr), .en(en_X), .q(X), .max(X_max)
  );
  count_mod #(.N(OW), .W(PW)) u_cnt_yo (
    .clk(clk), .clr(cnt_clr), .en(en_Y), .q(Y), .max(Y_max)
  );

  // Window decodes come from registered step and counters only.
  assign mac_en    = step_q;
  assign acc_clr   = step_q && (x == '0) && (y == '0);
  assign acc_valid = step_q && x_max && y_max;
  assign shift_x   = acc_valid && !X_max;
  assign shift_row = acc_valid && X_max && !Y_max;

  // Next-state selection for the pass sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (ld_we && (ld_idx == LAST_ADDR)) state_nxt = SCAN;
      SCAN:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, load address/strobe pipeline and registered status outputs.
  // Stall is registered into step_q so a cycle's step status is known at
  // its start, keeping stall off every output path.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      state    <= IDLE;
      addr_vld <= 1'b0;
      w_raddr  <= '0;
      ld_we    <= 1'b0;
      ld_idx   <= '0;
      step_q   <= 1'b0;
      busy     <= 1'b0;
      finish   <= 1'b0;
    end else begin
      state  <= state_nxt;
      step_q <= (state_nxt == SCAN) && !stall;
      busy   <= (state_nxt != IDLE);
      finish <= (state_nxt == DONE);
      ld_we  <= addr_vld;
      ld_idx <= addr_vld ? w_raddr : '0;
      if ((state == IDLE) && start) begin
        addr_vld <= 1'b1;
        w_raddr  <= '0;
      end else if (addr_vld) begin
        if (w_raddr == LAST_ADDR) begin
          addr_vld <= 1'b0;
          w_raddr  <= '0;
        end else begin
          w_raddr <= w_raddr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Bench for conv_scan_ctrl: step-count model checked every cycle plus literal pins.
module tb_conv_scan_ctrl;

  localparam int KW    = 3;
  localparam int OW    = 19;
  localparam int TOTAL = OW * OW * KW * KW;

  logic       clk = 1'b0;
  logic       xrst = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       busy, ld_we, mac_en, acc_clr, acc_valid, shift_x, shift_row, finish;
  logic [3:0] w_raddr, ld_idx;
  logic [1:0] x, y;
  logic [4:0] X, Y;

  int tot = 0;
  int bad = 0;

  conv_scan_ctrl dut (
    .clk(clk), .xrst(xrst), .start(start), .stall(stall), .busy(busy),
    .w_raddr(w_raddr), .ld_we(ld_we), .ld_idx(ld_idx),
    .x(x), .y(y), .X(X), .Y(Y),
    .mac_en(mac_en), .acc_clr(acc_clr), .acc_valid(acc_valid),
    .shift_x(shift_x), .shift_row(shift_row), .finish(finish)
  );

  always #5 clk = ~clk;

  // Model: phase (0 idle,1 load,2 scan,3 done), cycle within load, steps done.
  int ph = 0, lc = 0, s = 0, cyc = 0;
  bit stepnow = 1'b0, cmp_on = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!xrst) begin
      ph <= 0; lc <= 0; s <= 0; stepnow <= 1'b0; cmp_on <= 1'b1;
    end else begin
      case (ph)
        0: if (start) begin ph <= 1; lc <= 1; end
        1: if (lc == KW * KW + 1) begin ph <= 2; stepnow <= !stall; end
           else lc <= lc + 1;
        2: if (stepnow && (s + 1 == TOTAL)) begin
             ph <= 3; stepnow <= 1'b0; s <= 0;
           end else begin
             if (stepnow) s <= s + 1;
             stepnow <= !stall;
           end
        default: ph <= 0;
      endcase
    end
  end

  function automatic logic [29:0] model_vec();
    int xx, yy, xo, yo;
    bit m, av, lw;
    logic [3:0] wa, li;
    wa = (ph == 1 && lc <= KW * KW) ? 4'(lc - 1) : 4'd0;
    lw = (ph == 1 && lc >= 2);
    li = lw ? 4'(lc - 2) : 4'd0;
    xx = s % KW;
    yy = (s / KW) % KW;
    xo = (s / (KW * KW)) % OW;
    yo = s / (KW * KW * OW);
    m  = (ph == 2) && stepnow;
    av = m && xx == KW - 1 && yy == KW - 1;
    return {ph != 0, wa, lw, li, 2'(xx), 2'(yy), 5'(xo), 5'(yo), m,
            m && xx == 0 && yy == 0, av, av && xo < OW - 1,
            av && xo == OW - 1 && yo < OW - 1, ph == 3};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic tick();
    logic [29:0] dv, mv;
    @(negedge clk);
    if (cmp_on) begin
      dv = {busy, w_raddr, ld_we, ld_idx, x, y, X, Y, mac_en, acc_clr,
            acc_valid, shift_x, shift_row, finish};
      mv = model_vec();
      tot++;
      if (dv !== mv) begin
        bad++;
        $display("FAIL outputs cyc=%0d act=%h exp=%h", cyc, dv, mv);
      end
    end
  endtask

  // One full pass from a start pulse; pct = stall probability in percent.
  task automatic run_pass(input int pct, input bit poke);
    int kc, off, fin_off, last_off, nst;
    int n_mac, n_clr, n_val, n_sx, n_sr;
    bit seen;
    seen = 0; fin_off = 0; last_off = -10; nst = 0;
    n_mac = 0; n_clr = 0; n_val = 0; n_sx = 0; n_sr = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    kc = cyc;
    for (int n = 0; n < 12000 && !seen; n++) begin
      off = cyc - kc + 1;
      if (off >= 1 && off <= 9) chk("load_addr", w_raddr, off - 1);
      if (off >= 2 && off <= 10) chk("load_strobe", {ld_we, ld_idx}, {1'b1, 4'(off - 2)});
      if (mac_en) n_mac++;
      if (acc_clr) n_clr++;
      if (acc_valid) n_val++;
      if (shift_x) n_sx++;
      if (shift_row) n_sr++;
      if (off >= 11 && busy && !mac_en && !finish) nst++;
      if (mac_en && x == 2 && y == 2 && X == 18 && Y == 4)
        chk("row_wrap_shift", {shift_row, shift_x}, 2'b10);
      if (mac_en && x == 2 && y == 2 && X == 18 && Y == 18) begin
        chk("last_step_noshift", {shift_row, shift_x}, 0);
        last_off = off;
      end
      if (finish) begin
        seen = 1;
        fin_off = off;
      end else begin
        stall = (off >= 10) && ($urandom_range(99) < pct);
        start = poke && (off == 500);
        tick();
      end
    end
    stall = 1'b0;
    start = 1'b0;
    tick();
    chk("finish_seen", seen, 1);
    chk("finish_offset", fin_off, 3260 + nst);
    chk("finish_after_last", fin_off, last_off + 1);
    chk("mac_count", n_mac, 3249);
    chk("clr_count", n_clr, 361);
    chk("valid_count", n_val, 361);
    chk("shift_x_count", n_sx, 342);
    chk("shift_row_count", n_sr, 18);
    chk("busy_after_finish", busy, 0);
  endtask

  initial begin
    // Reset for three cycles, then idle.
    repeat (3) tick();
    xrst = 1'b1;
    repeat (10) tick();
    chk("idle_busy", busy, 0);
    chk("idle_counters", {x, y, X, Y}, 0);

    // Clean pass with a start poked mid-scan.
    run_pass(0, 1'b1);
    repeat (2) tick();

    // Pass with 30% stall.
    run_pass(30, 1'b0);
    repeat (2) tick();

    // Reset during LOAD at address 5.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("load_addr5", w_raddr, 5);
    xrst = 1'b0;
    tick();
    chk("rst_load_busy", busy, 0);
    chk("rst_load_addr", w_raddr, 0);
    xrst = 1'b1;
    repeat (3) tick();

    // Reset at SCAN step 1000 (cycle 1011 after the start edge).
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (1010) tick();
    chk("step1000_mac", mac_en, 1);
    chk("step1000_pos", {Y, X, y, x}, {5'd5, 5'd16, 2'd0, 2'd1});
    xrst = 1'b0;
    tick();
    chk("rst_scan_busy", busy, 0);
    chk("rst_scan_pos", {mac_en, Y, X, y, x}, 0);
    xrst = 1'b1;
    repeat (2) tick();

    // Fresh pass after the mid-operation resets.
    run_pass(0, 1'b0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
